controller_input_conditioner: RTL and testbench

Upstream stage between board pins and the game-logic block. Synchronises and debounces the two direction switches and two push buttons, and normalises button polarity. Produces one-cycle start pulses and a frame-aligned, acknowledged jump request for the per-frame game update. Also derives the per-frame tick from the VGA generator's vsync.

---
 rtl/controller_input_conditioner_pkg.sv | 29 ++
 rtl/controller_input_conditioner_debounce_channel.sv | 69 ++++++
 rtl/controller_input_conditioner.sv | 133 +++++++++++++
 tb/tb_controller_input_conditioner.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_input_conditioner_pkg.sv
// Shared types and channel indices for the controller input conditioner.
package controller_input_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } move_dir_t;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_JUMP  = 2;
    localparam int CH_START = 3;
    localparam int NUM_CH   = 4;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    // Opposing switches cancel each other rather than favouring one side.
    function automatic move_dir_t resolve_dir(input logic left, input logic right);
        move_dir_t dir;
        case ({left, right})
            2'b10:   dir = DIR_LEFT;
            2'b01:   dir = DIR_RIGHT;
            default: dir = DIR_NONE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/controller_input_conditioner_debounce_channel.sv
// One input channel: two-flop synchroniser followed by a stable-count debouncer.
// CONTROLLER_DEBOUNCE_BYPASS_EN removes the counter so the level follows s2 directly.
module debounce_channel
    import controller_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic s1_r;
    logic s2_r;
    logic stable_r;

`ifdef CONTROLLER_DEBOUNCE_BYPASS_EN

    // Synchroniser with the accepted level tracking s2 every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            stable_r <= 1'b0;
        end else begin
            s1_r     <= raw;
            s2_r     <= s1_r;
            stable_r <= s2_r;
        end
    end

`else

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;

    // Synchroniser plus counter; any disagreement that breaks early restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
            if (s2_r != stable_r) begin
                if (cnt_r == CNT_MAX) begin
                    stable_r <= s2_r;
                    cnt_r    <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end
    end

`endif

    assign level = stable_r;

endmodule

// File: rtl/controller_input_conditioner.sv
// Board-pin conditioner feeding the game logic: debounced controls, start/jump events, frame tick.
// Define CONTROLLER_DEBOUNCE_BYPASS_EN to replace debouncing with a plain synchroniser.
module controller_input_conditioner
    import controller_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int HOLD_WIDTH        = 8
) (
    input  logic                  vga_clock,
    input  logic                  reset,
    input  logic                  left_switch,
    input  logic                  right_switch,
    input  logic                  jump_button,
    input  logic                  start_button,
    input  logic                  vsync,
    input  logic                  jump_ack,
    output logic                  frame_tick,
    output logic                  move_left,
    output logic                  move_right,
    output logic                  jump_held,
    output logic                  jump_request,
    output logic [HOLD_WIDTH-1:0] jump_hold_frames,
    output logic                  start_pulse
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX  = {HOLD_WIDTH{1'b1}};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ZERO = {HOLD_WIDTH{1'b0}};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);

    logic [NUM_CH-1:0]     raw_s;
    logic [NUM_CH-1:0]     stable_s;
    logic                  jump_d_r;
    logic                  start_d_r;
    logic                  vsync_d_r;
    logic                  move_left_r;
    logic                  move_right_r;
    logic                  jump_request_r;
    logic                  start_pulse_r;
    logic [HOLD_WIDTH-1:0] hold_r;
    logic                  jump_rise_s;
    logic                  start_rise_s;
    logic                  frame_tick_s;

    // Normalise button polarity so every channel reads 1 = active from the first flop on.
    always_comb begin
        raw_s          = {NUM_CH{1'b0}};
        raw_s[CH_LEFT]  = left_switch;
        raw_s[CH_RIGHT] = right_switch;
        if (BUTTON_ACTIVE_LOW) begin
            raw_s[CH_JUMP]  = ~jump_button;
            raw_s[CH_START] = ~start_button;
        end else begin
            raw_s[CH_JUMP]  = jump_button;
            raw_s[CH_START] = start_button;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (vga_clock),
            .reset(reset),
            .raw  (raw_s[g]),
            .level(stable_s[g])
        );
    end

    assign jump_rise_s  = stable_s[CH_JUMP] & ~jump_d_r;
    assign start_rise_s = stable_s[CH_START] & ~start_d_r;
    assign frame_tick_s = vsync_d_r & ~vsync & ~reset;

    // Event generation, jump handshake and per-frame hold counter.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            jump_d_r       <= 1'b0;
            start_d_r      <= 1'b0;
            vsync_d_r      <= 1'b1;
            move_left_r    <= 1'b0;
            move_right_r   <= 1'b0;
            jump_request_r <= 1'b0;
            start_pulse_r  <= 1'b0;
            hold_r         <= HOLD_ZERO;
        end else begin
            jump_d_r      <= stable_s[CH_JUMP];
            start_d_r     <= stable_s[CH_START];
            vsync_d_r     <= vsync;
            start_pulse_r <= start_rise_s;

            case (resolve_dir(stable_s[CH_LEFT], stable_s[CH_RIGHT]))
                DIR_LEFT: begin
                    move_left_r  <= 1'b1;
                    move_right_r <= 1'b0;
                end
                DIR_RIGHT: begin
                    move_left_r  <= 1'b0;
                    move_right_r <= 1'b1;
                end
                default: begin
                    move_left_r  <= 1'b0;
                    move_right_r <= 1'b0;
                end
            endcase

            // A fresh press outranks a simultaneous acknowledge.
            if (jump_rise_s) begin
                jump_request_r <= 1'b1;
            end else if (jump_ack) begin
                jump_request_r <= 1'b0;
            end else begin
                jump_request_r <= jump_request_r;
            end

            if (!stable_s[CH_JUMP]) begin
                hold_r <= HOLD_ZERO;
            end else if (frame_tick_s && (hold_r != HOLD_MAX)) begin
                hold_r <= hold_r + HOLD_ONE;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    assign frame_tick       = frame_tick_s;
    assign move_left        = move_left_r;
    assign move_right       = move_right_r;
    assign jump_held        = stable_s[CH_JUMP];
    assign jump_request     = jump_request_r;
    assign jump_hold_frames = hold_r;
    assign start_pulse      = start_pulse_r;

endmodule

// File: tb/tb_controller_input_conditioner.sv
// Directed bench for controller_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_controller_input_conditioner;

    localparam int DEB = 4;

    logic       vga_clock = 1'b0;
    logic       reset = 1'b1;
    logic       left_switch = 1'b0;
    logic       right_switch = 1'b0;
    logic       jump_button = 1'b1;
    logic       start_button = 1'b1;
    logic       vsync = 1'b1;
    logic       jump_ack = 1'b0;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       jump_held;
    logic       jump_request;
    logic [7:0] jump_hold_frames;
    logic       start_pulse;

    int checks = 0;
    int errors = 0;

    always #5 vga_clock = ~vga_clock;

    controller_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .BUTTON_ACTIVE_LOW(1'b1),
        .HOLD_WIDTH(8)
    ) dut (
        .vga_clock       (vga_clock),
        .reset           (reset),
        .left_switch     (left_switch),
        .right_switch    (right_switch),
        .jump_button     (jump_button),
        .start_button    (start_button),
        .vsync           (vsync),
        .jump_ack        (jump_ack),
        .frame_tick      (frame_tick),
        .move_left       (move_left),
        .move_right      (move_right),
        .jump_held       (jump_held),
        .jump_request    (jump_request),
        .jump_hold_frames(jump_hold_frames),
        .start_pulse     (start_pulse)
    );

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge vga_clock);
        #1;
    endtask

    task automatic test_reset;
        logic [5:0] outs;
        cyc(3);
        outs = {frame_tick, move_left, move_right, jump_held, jump_request, start_pulse};
        checks++;
        if (outs !== 6'b0 || jump_hold_frames !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%0d, want 000000/0", outs, jump_hold_frames);
        end
        @(negedge vga_clock) reset = 1'b0;
        cyc(10);
        outs = {frame_tick, move_left, move_right, jump_held, jump_request, start_pulse};
        checks++;
        if (outs !== 6'b0 || jump_hold_frames !== 8'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %b/%0d, want 000000/0", outs, jump_hold_frames);
        end
    endtask

`ifndef CONTROLLER_DEBOUNCE_BYPASS_EN

    task automatic test_jump;
        @(negedge vga_clock) jump_button = 1'b0;
        cyc(5);
        checks++;
        if (jump_held !== 1'b0) begin
            errors++;
            $display("FAIL jump_held_edge5: got %b, want 0", jump_held);
        end
        cyc(1);
        checks++;
        if (jump_held !== 1'b1 || jump_request !== 1'b0) begin
            errors++;
            $display("FAIL jump_held_edge6: got held=%b req=%b, want held=1 req=0", jump_held, jump_request);
        end
        cyc(1);
        checks++;
        if (jump_request !== 1'b1) begin
            errors++;
            $display("FAIL jump_request_edge7: got %b, want 1", jump_request);
        end
        cyc(3);
        checks++;
        if (jump_request !== 1'b1) begin
            errors++;
            $display("FAIL jump_request_edge10: got %b, want 1", jump_request);
        end
        @(negedge vga_clock) jump_ack = 1'b1;
        cyc(1);
        checks++;
        if (jump_request !== 1'b0) begin
            errors++;
            $display("FAIL jump_ack_clear: got %b, want 0", jump_request);
        end
        @(negedge vga_clock) jump_ack = 1'b0;
        @(negedge vga_clock) jump_ack = 1'b1;
        @(negedge vga_clock) jump_ack = 1'b0;
        cyc(1);
        checks++;
        if (jump_request !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: got %b, want 0", jump_request);
        end
        @(negedge vga_clock) jump_button = 1'b1;
        cyc(8);
        checks++;
        if (jump_held !== 1'b0) begin
            errors++;
            $display("FAIL jump_release: got %b, want 0", jump_held);
        end
    endtask

    task automatic test_press_with_ack;
        @(negedge vga_clock) jump_button = 1'b0;
        cyc(7);
        @(negedge vga_clock) jump_button = 1'b1;
        cyc(8);
        checks++;
        if (jump_request !== 1'b1 || jump_held !== 1'b0) begin
            errors++;
            $display("FAIL request_sticky: got req=%b held=%b, want req=1 held=0", jump_request, jump_held);
        end
        @(negedge vga_clock) jump_button = 1'b0;
        cyc(6);
        @(negedge vga_clock) jump_ack = 1'b1;
        cyc(1);
        checks++;
        if (jump_request !== 1'b1) begin
            errors++;
            $display("FAIL press_wins_edge7: got %b, want 1", jump_request);
        end
        @(negedge vga_clock) jump_ack = 1'b0;
        cyc(1);
        checks++;
        if (jump_request !== 1'b1) begin
            errors++;
            $display("FAIL press_wins_edge8: got %b, want 1", jump_request);
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] outs;
        @(negedge vga_clock) left_switch = 1'b1;
        cyc(3);
        @(negedge vga_clock) reset = 1'b1;
        cyc(1);
        outs = {frame_tick, move_left, move_right, jump_held, jump_request, start_pulse};
        checks++;
        if (outs !== 6'b0 || jump_hold_frames !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b/%0d, want 000000/0", outs, jump_hold_frames);
        end
        cyc(1);
        @(negedge vga_clock) reset = 1'b0;
        cyc(6);
        checks++;
        if (jump_held !== 1'b1 || jump_request !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_edge6: got held=%b req=%b, want held=1 req=0", jump_held, jump_request);
        end
        cyc(1);
        checks++;
        if (jump_request !== 1'b1 || move_left !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_edge7: got req=%b left=%b, want req=1 left=1", jump_request, move_left);
        end
        @(negedge vga_clock) begin
            left_switch = 1'b0;
            jump_button = 1'b1;
            jump_ack    = 1'b1;
        end
        @(negedge vga_clock) jump_ack = 1'b0;
        cyc(10);
        checks++;
        if (jump_request !== 1'b0 || move_left !== 1'b0 || jump_held !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got req=%b left=%b held=%b, want 0 0 0", jump_request, move_left, jump_held);
        end
    endtask

    task automatic test_direction;
        @(negedge vga_clock) left_switch = 1'b1;
        cyc(6);
        checks++;
        if (move_left !== 1'b0) begin
            errors++;
            $display("FAIL left_edge6: got %b, want 0", move_left);
        end
        cyc(1);
        checks++;
        if (move_left !== 1'b1 || move_right !== 1'b0) begin
            errors++;
            $display("FAIL left_edge7: got L=%b R=%b, want L=1 R=0", move_left, move_right);
        end
        @(negedge vga_clock) right_switch = 1'b1;
        cyc(6);
        checks++;
        if (move_left !== 1'b1 || move_right !== 1'b0) begin
            errors++;
            $display("FAIL conflict_edge6: got L=%b R=%b, want L=1 R=0", move_left, move_right);
        end
        cyc(1);
        checks++;
        if (move_left !== 1'b0 || move_right !== 1'b0) begin
            errors++;
            $display("FAIL conflict_edge7: got L=%b R=%b, want L=0 R=0", move_left, move_right);
        end
        @(negedge vga_clock) left_switch = 1'b0;
        cyc(6);
        checks++;
        if (move_right !== 1'b0) begin
            errors++;
            $display("FAIL right_edge6: got %b, want 0", move_right);
        end
        cyc(1);
        checks++;
        if (move_right !== 1'b1 || move_left !== 1'b0) begin
            errors++;
            $display("FAIL right_edge7: got L=%b R=%b, want L=0 R=1", move_left, move_right);
        end
        @(negedge vga_clock) right_switch = 1'b0;
        cyc(8);
    endtask

    task automatic test_start_glitch;
        int highs;
        int first;
        highs = 0;
        @(negedge vga_clock) start_button = 1'b0;
        repeat (3) @(negedge vga_clock);
        start_button = 1'b1;
        repeat (20) begin
            cyc(1);
            if (start_pulse === 1'b1) highs++;
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL start_glitch_rejected: got %0d pulse cycles, want 0", highs);
        end
        highs = 0;
        first = -1;
        @(negedge vga_clock) start_button = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            cyc(1);
            if (start_pulse === 1'b1) begin
                highs++;
                if (first < 0) first = e;
            end
            if (e == 6) start_button = 1'b1;
        end
        checks++;
        if (highs !== 1 || first !== 7) begin
            errors++;
            $display("FAIL start_pulse_single: got %0d cycles first at %0d, want 1 at 7", highs, first);
        end
    endtask

    task automatic test_hold_frames;
        logic [7:0] want;
        // jump_held rises on the same edge a frame tick is consumed: counts 0.
        @(negedge vga_clock) jump_button = 1'b0;
        cyc(5);
        @(negedge vga_clock) vsync = 1'b0;
        cyc(1);
        checks++;
        if (jump_held !== 1'b1 || jump_hold_frames !== 8'd0) begin
            errors++;
            $display("FAIL hold_coincident: got held=%b frames=%0d, want held=1 frames=0", jump_held, jump_hold_frames);
        end
        @(negedge vga_clock) vsync = 1'b1;
        cyc(2);
        for (int i = 1; i <= 300; i++) begin
            want = (i > 255) ? 8'd255 : 8'(i);
            @(negedge vga_clock) vsync = 1'b0;
            #1;
            checks++;
            if (frame_tick !== 1'b1) begin
                errors++;
                $display("FAIL tick_high frame %0d: got %b, want 1", i, frame_tick);
            end
            cyc(1);
            checks++;
            if (frame_tick !== 1'b0 || jump_hold_frames !== want) begin
                errors++;
                $display("FAIL hold_count frame %0d: got tick=%b frames=%0d, want tick=0 frames=%0d",
                         i, frame_tick, jump_hold_frames, want);
            end
            @(negedge vga_clock) vsync = 1'b1;
            cyc(1);
        end
        @(negedge vga_clock) jump_button = 1'b1;
        cyc(6);
        checks++;
        if (jump_held !== 1'b0 || jump_hold_frames !== 8'd255) begin
            errors++;
            $display("FAIL hold_release_edge6: got held=%b frames=%0d, want held=0 frames=255", jump_held, jump_hold_frames);
        end
        cyc(1);
        checks++;
        if (jump_hold_frames !== 8'd0) begin
            errors++;
            $display("FAIL hold_release_edge7: got %0d, want 0", jump_hold_frames);
        end
    endtask

`else

    task automatic test_bypass;
        @(negedge vga_clock) right_switch = 1'b1;
        cyc(3);
        checks++;
        if (move_right !== 1'b0) begin
            errors++;
            $display("FAIL bypass_right_edge3: got %b, want 0", move_right);
        end
        cyc(1);
        checks++;
        if (move_right !== 1'b1) begin
            errors++;
            $display("FAIL bypass_right_edge4: got %b, want 1", move_right);
        end
        @(negedge vga_clock) right_switch = 1'b0;
        cyc(5);
        @(negedge vga_clock) left_switch = 1'b1;
        @(negedge vga_clock) left_switch = 1'b0;
        cyc(2);
        checks++;
        if (move_left !== 1'b0) begin
            errors++;
            $display("FAIL bypass_glitch_edge3: got %b, want 0", move_left);
        end
        cyc(1);
        checks++;
        if (move_left !== 1'b1) begin
            errors++;
            $display("FAIL bypass_glitch_edge4: got %b, want 1", move_left);
        end
        cyc(1);
        checks++;
        if (move_left !== 1'b0) begin
            errors++;
            $display("FAIL bypass_glitch_edge5: got %b, want 0", move_left);
        end
    endtask

`endif

    initial begin
        test_reset();
`ifndef CONTROLLER_DEBOUNCE_BYPASS_EN
        test_jump();
        test_press_with_ack();
        test_reset_mid();
        test_direction();
        test_start_glitch();
        test_hold_frames();
`else
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
